lbus_master: RTL and testbench
==============================

// Module: lbus_master
// PURPOSE
//  Initiator for the 8-bit-address / 32-bit-data local bus that the trigger channel Register,
//  Lanalyzer0 and per-channel register blocks respond to. Takes one command at a time through a
//  valid/ready handshake from the host link decoder, drives Address/DataIn/Read/Write, samples the
//  ORed DataOut and returns one response per command. Sits between the host link and all bus slaves.
// PARAMETERS
//  RD_WAIT   4'd3    cycles Read is held before DataOut is sampled (1..15; 0 treated as 1)
//  TIMEOUT   8'd64   max cycles waiting for ack (LBUS_ACK_EN only); 0 disables timeout
// PORTS
//  clk        in   1   system clock (50 MHz domain, clk[2] of the channel)
//  rst        in   1   synchronous, active-high reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   master accepts command this cycle
//  cmd_write  in   1   1=write, 0=read
//  cmd_addr   in   8   target register address
//  cmd_wdata  in   32  write data (ignored on read)
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   host consumes response
//  rsp_rdata  out  32  read data (0 for writes)
//  rsp_err    out  1   1 = ack timeout (LBUS_ACK_EN only; else 0)
//  Address    out  8   bus address
//  DataIn     out  32  bus write data, to slaves' DataIn
//  Read       out  1   bus read strobe
//  Write      out  1   bus write strobe
//  DataOut    in   32  ORed slave read data (non-selected slaves drive 0)
//  ack        in   1   ORed slave ack (used only with LBUS_ACK_EN)
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready=0 then 1 from first post-reset cycle; rsp_valid=0, rsp_rdata=0,
//    rsp_err=0, Address=0, DataIn=0, Read=0, Write=0, counters 0. Reset mid-transaction aborts it;
//    no response is produced for the aborted command.
//  - cmd_ready = (state==IDLE). Command accepted on cmd_valid&cmd_ready; fields latched that edge.
//  - FSM: IDLE -> WR (write) | RD (read). WR: Address/DataIn driven, Write=1 for exactly 1 cycle,
//    then RSP. RD: Address driven, Read=1, wait counter counts 0..RD_WAIT-1; on last count
//    rsp_rdata<=DataOut, Read drops next cycle, -> RSP. RSP: rsp_valid=1, held with stable data
//    until rsp_ready; on rsp_valid&rsp_ready -> IDLE. Response and next accept never overlap.
//  - Latency (rsp_ready tied 1): write accept->rsp_valid = 2 cycles; read = RD_WAIT+1 cycles.
//  - Address and DataIn hold their last values in IDLE (no glitch to 0); Read/Write never both 1.
//  - Write responses: rsp_rdata=0, rsp_err=0. Read of unmapped address returns 0 (OR bus idle).
//  - Wait counter 4 bits, saturating; no wrap. Only one outstanding command (no pipelining).
// CONFIGURATION
//  LBUS_ACK_EN defined: RD and WR states stay until ack=1 (sample DataOut on ack cycle, strobe
//    drops next cycle) or until TIMEOUT cycles elapse -> RSP with rsp_err=1, rsp_rdata=0.
//    8-bit timeout counter, cleared on each accept. ack in same cycle as timeout: ack wins.
//    RD_WAIT ignored. Write strobe held until ack/timeout.
//  LBUS_ACK_EN undefined: ack ignored, fixed timing above, rsp_err constant 0.
// TESTING
//  1 Write 0x1C<-0x0000F0F0 -> Write high 1 cycle with Address=0x1C DataIn=0x0000F0F0; rsp_valid 2 cycles after accept, rsp_rdata=0.
//  2 Read 0x1E, slave model drives DataOut=0x0F000000 after 2 cycles -> rsp_rdata=0x0F000000, Read high RD_WAIT=3 cycles.
//  3 rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, second cmd_valid not accepted.
//  4 Back-to-back cmd_valid, rsp_ready=1: write then read -> no cycle with Read&Write, exactly 2 responses in order.
//  5 rst asserted during RD -> next cycle Read=0, rsp_valid=0, cmd_ready=1; no stale response emitted.
//  6 LBUS_ACK_EN, TIMEOUT=64, no ack on read -> rsp_err=1, rsp_rdata=0 at 64 cycles; ack at cycle 5 -> rsp_err=0, data from cycle 5.

Source files
------------

// File: rtl/lbus_master.sv
// Local bus initiator: accepts one command at a time, drives Address/DataIn/Read/Write, returns one response.
// Define LBUS_ACK_EN to end strobes on slave ack (bounded by TIMEOUT) instead of fixed RD_WAIT timing.

module lbus_master #(
  parameter logic [3:0] RD_WAIT = 4'd3,
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  Address,
  output logic [31:0] DataIn,
  output logic        Read,
  output logic        Write,
  input  logic [31:0] DataOut,
  input  logic        ack
);

  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

  state_t state;

`ifdef LBUS_ACK_EN
  logic [7:0] tmo_cnt;
  logic       tmo_hit;
  logic       unused_ok;

  // TIMEOUT of zero means wait for ack indefinitely.
  assign tmo_hit   = (TIMEOUT != 8'd0) && (tmo_cnt == TIMEOUT - 8'd1);
  assign unused_ok = ^RD_WAIT;
`else
  localparam logic [3:0] RD_LAST = (RD_WAIT == 4'd0) ? 4'd0 : RD_WAIT - 4'd1;

  logic [3:0] wait_cnt;
  logic       unused_ok;

  assign unused_ok = ^{ack, TIMEOUT};
`endif

  // NOTE: sequential state uses <= only, so every branch sees pre-edge values of all registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      Address   <= 8'd0;
      DataIn    <= 32'd0;
      Read      <= 1'b0;
      Write     <= 1'b0;
`ifdef LBUS_ACK_EN
      tmo_cnt   <= 8'd0;
`else
      wait_cnt  <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            Address   <= cmd_addr;
`ifdef LBUS_ACK_EN
            tmo_cnt   <= 8'd0;
`else
            wait_cnt  <= 4'd0;
`endif
            if (cmd_write) begin
              DataIn <= cmd_wdata;
              Write  <= 1'b1;
              state  <= WR;
            end else begin
              // DataIn keeps its last value so the bus never glitches on reads.
              Read   <= 1'b1;
              state  <= RD;
            end
          end
        end

        WR: begin
`ifdef LBUS_ACK_EN
          if (ack || tmo_hit) begin
            Write     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= 32'd0;
            rsp_err   <= ~ack;
            state     <= RSP;
          end else begin
            tmo_cnt <= tmo_cnt + {7'd0, tmo_cnt != 8'hFF};
          end
`else
          Write     <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
          state     <= RSP;
`endif
        end

        RD: begin
`ifdef LBUS_ACK_EN
          // Ack wins over a timeout landing in the same cycle.
          if (ack || tmo_hit) begin
            Read      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= ack ? DataOut : 32'd0;
            rsp_err   <= ~ack;
            state     <= RSP;
          end else begin
            tmo_cnt <= tmo_cnt + {7'd0, tmo_cnt != 8'hFF};
          end
`else
          if (wait_cnt == RD_LAST) begin
            Read      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= DataOut;
            rsp_err   <= 1'b0;
            state     <= RSP;
          end else if (wait_cnt != 4'hF) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
`endif
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lbus_master.sv
// Self-checking bench for lbus_master: randomized commands against a memory-level bus model.
// Slave model maps addresses below 0xC0; higher addresses read back as zero.

module tb_lbus_master;

  localparam logic [3:0] RD_WAIT = 4'd3;
  localparam logic [7:0] TIMEOUT = 8'd64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = 8'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  Address;
  logic [31:0] DataIn;
  logic        Read;
  logic        Write;
  logic [31:0] DataOut;
  logic        ack;

  int checks = 0;
  int failures = 0;

  logic [31:0] ref_mem   [256] = '{default: 32'd0};
  logic [31:0] slave_mem [256] = '{default: 32'd0};
  int          rd_cycles = 0;
  int          strobe_cycles = 0;
  int          ack_cycle = 0;

  always #5 clk = ~clk;

  lbus_master #(.RD_WAIT(RD_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Address(Address), .DataIn(DataIn), .Read(Read), .Write(Write),
    .DataOut(DataOut), .ack(ack)
  );

  function automatic logic mapped(input logic [7:0] a);
    return a < 8'hC0;
  endfunction

  // Slave: stores writes, presents read data only from the third Read cycle onward.
  always @(posedge clk) begin
    if (Write && mapped(Address)) slave_mem[Address] <= DataIn;
    rd_cycles     <= Read ? rd_cycles + 1 : 0;
    strobe_cycles <= (Read || Write) ? strobe_cycles + 1 : 0;
  end

  assign DataOut = (Read && rd_cycles >= 2 && mapped(Address)) ? slave_mem[Address] : 32'd0;
  assign ack     = (ack_cycle != 0) && (Read || Write) && (strobe_cycles == ack_cycle - 1);

  // Bus protocol watcher: strobes exclusive, strobe lengths fixed in the default build.
`ifndef LBUS_ACK_EN
  int rd_run = 0;
  int wr_run = 0;
`endif
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (Read && Write) begin
        failures++;
        $display("FAIL strobe_overlap: Read=%b Write=%b, required not both 1", Read, Write);
      end
    end
`ifndef LBUS_ACK_EN
    if (rst) begin
      rd_run = 0;
      wr_run = 0;
    end else begin
      if (Write) wr_run++;
      else if (wr_run != 0) begin
        checks++;
        if (wr_run != 1) begin
          failures++;
          $display("FAIL write_pulse_len: got %0d cycles, required 1", wr_run);
        end
        wr_run = 0;
      end
      if (Read) rd_run++;
      else if (rd_run != 0) begin
        checks++;
        if (rd_run != int'(RD_WAIT)) begin
          failures++;
          $display("FAIL read_pulse_len: got %0d cycles, required %0d", rd_run, RD_WAIT);
        end
        rd_run = 0;
      end
    end
`endif
  end

  function automatic int expected_latency(input logic wr);
`ifdef LBUS_ACK_EN
    return (ack_cycle == 0) ? int'(TIMEOUT) + 1 : ack_cycle + 1;
`else
    return wr ? 2 : int'(RD_WAIT) + 1;
`endif
  endfunction

  // One complete command; hold = cycles of rsp_ready low, poke = offer a competing command meanwhile.
  task automatic run_cmd(input string name, input logic wr, input logic [7:0] a,
                         input logic [31:0] d, input int hold, input logic poke);
    logic [31:0] exp_data;
    logic        exp_err;
    logic [31:0] held;
    int          exp_lat;
    int          lat;
    int          n;
    if (wr) begin
      if (mapped(a)) ref_mem[a] = d;
      exp_data = 32'd0;
    end else begin
      exp_data = mapped(a) ? ref_mem[a] : 32'd0;
    end
    exp_err = 1'b0;
`ifdef LBUS_ACK_EN
    if (ack_cycle == 0) begin
      exp_err  = 1'b1;
      exp_data = 32'd0;
    end
`endif
    exp_lat = expected_latency(wr);

    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_accept_wait: cmd_ready=%b after %0d cycles, required 1", name, cmd_ready, n);
    end

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = $urandom;

    checks++;
    if ({Write, Read, Address} !== {wr, ~wr, a}) begin
      failures++;
      $display("FAIL %s_strobe: got W=%b R=%b A=%h, required W=%b R=%b A=%h",
               name, Write, Read, Address, wr, ~wr, a);
    end
    if (wr) begin
      checks++;
      if (DataIn !== d) begin
        failures++;
        $display("FAIL %s_datain: got %h, required %h", name, DataIn, d);
      end
    end

    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || lat != exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles (rsp_valid=%b), required %0d", name, lat, rsp_valid, exp_lat);
    end
    checks++;
    if (rsp_rdata !== exp_data || rsp_err !== exp_err) begin
      failures++;
      $display("FAIL %s_response: got data=%h err=%b, required data=%h err=%b",
               name, rsp_rdata, rsp_err, exp_data, exp_err);
    end

    held = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a ^ 8'h01; cmd_wdata = $urandom;
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== held || cmd_ready !== 1'b0 || Read || Write) begin
        failures++;
        $display("FAIL %s_hold: got valid=%b data=%h ready=%b R=%b W=%b, required 1/%h/0/0/0",
                 name, rsp_valid, rsp_rdata, cmd_ready, Read, Write, held);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || Address !== a) begin
      failures++;
      $display("FAIL %s_release: got valid=%b ready=%b A=%h, required 0/1/%h",
               name, rsp_valid, cmd_ready, Address, a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, Read, Write} !== 5'b0 || rsp_rdata !== 32'd0 ||
        Address !== 8'd0 || DataIn !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: got ready=%b valid=%b err=%b R=%b W=%b data=%h A=%h D=%h, required all 0",
               cmd_ready, rsp_valid, rsp_err, Read, Write, rsp_rdata, Address, DataIn);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    run_cmd("t1_write", 1'b1, 8'h1C, 32'h0000F0F0, 0, 1'b0);
  endtask

  task automatic test_read();
    run_cmd("t2_seed", 1'b1, 8'h1E, 32'h0F000000, 0, 1'b0);
    run_cmd("t2_read", 1'b0, 8'h1E, 32'd0, 0, 1'b0);
    run_cmd("t2_unmapped", 1'b0, 8'hF3, 32'd0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_cmd("t3_hold_read", 1'b0, 8'h1C, 32'd0, 10, 1'b1);
    run_cmd("t3_check_poke", 1'b0, 8'h1D, 32'd0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic        cw [6];
    logic [7:0]  ca [6];
    logic [31:0] cd [6];
    logic [31:0] expd [6];
    int          idx = 0;
    int          got = 0;
    logic        acc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cw[i] = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom);
      ca[i] = (i == 1) ? ca[0] : 8'($urandom_range(0, 8'hCF));
      cd[i] = $urandom;
      if (cw[i]) begin
        if (mapped(ca[i])) ref_mem[ca[i]] = cd[i];
        expd[i] = 32'd0;
      end else begin
        expd[i] = mapped(ca[i]) ? ref_mem[ca[i]] : 32'd0;
      end
    end
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      if (idx < 6) begin
        cmd_valid = 1'b1; cmd_write = cw[idx]; cmd_addr = ca[idx]; cmd_wdata = cd[idx];
      end else begin
        cmd_valid = 1'b0;
      end
      acc = cmd_valid && cmd_ready;
      @(negedge clk);
      if (acc) idx++;
      if (rsp_valid === 1'b1) begin
        checks++;
        if (rsp_rdata !== expd[got]) begin
          failures++;
          $display("FAIL t4_b2b_rsp%0d: got %h, required %h", got, rsp_rdata, expd[got]);
        end
        got++;
      end
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (got != 6 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL t4_b2b_count: got %0d responses (valid=%b), required 6", got, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_read();
    int quiet = 1;
    while (cmd_ready !== 1'b1) @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h1E;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (Read !== 1'b1) begin
      failures++;
      $display("FAIL t5_read_started: got Read=%b, required 1", Read);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (Read !== 1'b0 || Write !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL t5_abort: got R=%b W=%b valid=%b, required 0/0/0", Read, Write, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL t5_ready: got cmd_ready=%b, required 1", cmd_ready);
    end
    rsp_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || Read !== 1'b0) quiet = 0;
    end
    rsp_ready = 1'b0;
    checks++;
    if (quiet != 1) begin
      failures++;
      $display("FAIL t5_stale_rsp: got activity after reset, required none");
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [4] = '{8'h1C, 8'h1E, 8'h40, 8'hC5};
    logic [7:0] a;
    logic       wr;
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom);
      a  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : 8'($urandom);
      run_cmd("rand", wr, a, $urandom, $urandom_range(0, 2), 1'b0);
    end
  endtask

`ifdef LBUS_ACK_EN
  task automatic test_ack_timeout();
    ack_cycle = 0;
    run_cmd("t6_timeout_rd", 1'b0, 8'h1E, 32'd0, 0, 1'b0);
    run_cmd("t6_timeout_wr", 1'b1, 8'h22, 32'hA5A5_0001, 0, 1'b0);
    ack_cycle = 5;
    run_cmd("t6_ack_rd", 1'b0, 8'h1E, 32'd0, 0, 1'b0);
    run_cmd("t6_ack_wr", 1'b1, 8'h23, 32'h1234_5678, 0, 1'b0);
    run_cmd("t6_ack_rd2", 1'b0, 8'h23, 32'd0, 0, 1'b0);
    ack_cycle = 3;
  endtask
`endif

  initial begin
`ifdef LBUS_ACK_EN
    ack_cycle = 3;
`else
    ack_cycle = 1;
`endif
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
`ifdef LBUS_ACK_EN
    test_ack_timeout();
`endif
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
